mul_div_unit: RTL
=================

# mul_div_unit

- Iterative 32-bit multiply/divide unit for the MIPS EX stage.
- Takes the same src1/src2 operands the ALU receives from the ID/EX register.
- Computes MULT/MULTU/DIV/DIVU over 33 cycles into architectural HI/LO registers. HI/LO feed the EX-stage result mux (MFHI/MFLO) beside the ALU result.
- The hazard unit holds the pipeline while busy_o is high.

## Interface
Parameters:
- none; widths fixed at 32 (operands, HI, LO) and 6 (iteration counter).

Ports:
- clk_i  in  1  clock; all state updates on the rising edge
- rst_i  in  1  reset; synchronous, active-low
- start_i  in  1  request an operation; sampled only in IDLE
- op_i  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start_i
- src1_i  in  32  rs operand: multiplicand or dividend; also data for HI/LO writes
- src2_i  in  32  rt operand: multiplier or divisor; sampled with start_i
- hi_we_i  in  1  MTHI: HI <= src1_i; honoured only in IDLE
- lo_we_i  in  1  MTLO: LO <= src1_i; honoured only in IDLE
- busy_o  out  1  high whenever state != IDLE
- done_o  out  1  one-cycle pulse; HI/LO hold the new result
- div_zero_o  out  1  one-cycle pulse with done_o when a DIV/DIVU had src2 == 0
- hi_o  out  32  HI register
- lo_o  out  32  LO register

## Operation
- States:
  - IDLE: on start_i, latch |src1|, |src2|, op and result signs, clear the accumulator and counter, go to CALC.
  - CALC: one iteration per cycle; counter 0..31; after iteration 31, go to FIX.
  - FIX: apply signs, write HI/LO, pulse done_o, go to IDLE.
- Multiply:
  - Radix-2 shift-add on the 64-bit {acc, multiplier} register.
  - Signed ops use magnitudes; the 64-bit product is negated in FIX if sign(src1) != sign(src2).
  - HI = product[63:32], LO = product[31:0].
- Divide:
  - Restoring division; 32-bit remainder, 32-bit quotient, one quotient bit per cycle.
  - Signed ops: quotient negated if signs differ; remainder takes the dividend's sign.
  - LO = quotient, HI = remainder.
- Divide by zero (both DIV and DIVU):
  - LO = 32'hFFFFFFFF, HI = src1_i as latched at start; div_zero_o = 1.
  - Full latency still applies.
- Signed overflow, DIV with -2^31 / -1: LO = 32'h80000000, HI = 0 (two's-complement wrap); no flag.
- hi_we_i/lo_we_i:
  - Take effect at the edge only in IDLE; ignored while busy.
  - Simultaneous with start_i: the write lands, and the later FIX write overwrites it.
- start_i while busy: ignored; no queueing.
- Pipeline stall is external: the hazard unit must keep src/op stable only for the sampling cycle.

## Timing
- Reset values (rst_i low at an edge, from any state):
  - state IDLE, counter 0
  - hi_o = 0, lo_o = 0
  - busy_o = 0, done_o = 0, div_zero_o = 0
- Reset mid-operation aborts the operation; HI/LO are cleared and no done_o is produced.
- Cycle timing, with start sampled at edge E0:
  - busy_o is high from after E0 through E33.
  - CALC iterations occur at E1..E32.
  - FIX occurs at E33: HI/LO update, done_o = 1 for one cycle, busy_o = 0.
- Latency is 33 cycles from sampling edge to HI/LO valid, independent of operands.
- A new start_i is accepted in the cycle done_o is high (back-to-back issue every 34 edges).
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- MDU_DIV_EN, defined: the divide datapath is built as described.
- MDU_DIV_EN, undefined:
  - Divide logic is not synthesised.
  - DIV/DIVU are still accepted with identical 33-cycle busy/done timing.
  - They produce HI = 0, LO = 0, div_zero_o = 0, so stall logic is unchanged.

## Test plan
- Reset then MULTU src1=32'hFFFFFFFF, src2=32'hFFFFFFFF -> done_o 33 cycles after start; HI=32'hFFFFFFFE, LO=32'h00000001.
- MULT src1=-7 (32'hFFFFFFF9), src2=6 -> HI=32'hFFFFFFFF, LO=32'hFFFFFFD6.
- DIV src1=-7, src2=2 -> LO=32'hFFFFFFFD (-3), HI=32'hFFFFFFFF (-1); DIVU 100/7 -> LO=14, HI=2.
- DIVU src1=5, src2=0 -> LO=32'hFFFFFFFF, HI=5, div_zero_o pulses with done_o; with MDU_DIV_EN undefined -> HI=LO=0, no div_zero_o.
- Reset at the 10th CALC cycle -> busy_o low next cycle, HI=LO=0, no done_o; a following MULTU 3*4 -> LO=12, HI=0.
- start_i and hi_we_i pulsed while busy -> ignored; start_i on the done_o cycle -> accepted; MTLO src1=32'h1234 in IDLE -> lo_o=32'h1234 next cycle.

Source files
------------

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative 32-bit multiply/divide unit for the MIPS EX stage.
//
// MULT/MULTU use radix-2 shift-add on magnitudes; DIV/DIVU use restoring
// division on magnitudes. Either way the operation takes one IDLE sampling
// edge, 32 CALC edges and one FIX edge, so HI/LO are valid 33 cycles after
// start_i is sampled, whatever the operands.
//
// Build option: define MDU_DIV_EN to build the divide datapath. Without it,
// DIV/DIVU still run the full 33-cycle busy/done sequence but return
// HI = 0, LO = 0 and never raise div_zero_o, so the hazard unit sees the
// same stall behaviour in both builds.
module mul_div_unit (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [1:0]  op_i,
  input  logic [31:0] src1_i,
  input  logic [31:0] src2_i,
  input  logic        hi_we_i,
  input  logic        lo_we_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        div_zero_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

  // Two's-complement negation of a 32-bit word.
  function automatic logic [31:0] neg32(input logic [31:0] v);
    return (~v) + 32'd1;
  endfunction

  // Two's-complement negation of a 64-bit product.
  function automatic logic [63:0] neg64(input logic [63:0] v);
    return (~v) + 64'd1;
  endfunction

  // Magnitude of an operand; unsigned ops pass the operand through.
  // |-2^31| comes out as 32'h80000000, which is correct read as unsigned.
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? neg32(v) : v;
  endfunction

  // Architectural and control state
  state_t      state_q;
  logic [5:0]  cnt_q;
  logic        busy_q;
  logic        done_q;
  logic        dz_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;

  // Operation context latched at start
  logic        is_div_q;   // 1: DIV/DIVU, 0: MULT/MULTU
  logic        neg_res_q;  // negate product / quotient in FIX
  logic [31:0] opnd_q;     // multiplicand magnitude or divisor magnitude

  // Working registers: {acc, work} is the 64-bit shift register.
  // Multiply: acc = upper partial product, work = multiplier shifting out.
  // Divide:   acc = partial remainder,     work = dividend in / quotient out.
  logic [31:0] acc_q;
  logic [31:0] work_q;
  logic [31:0] acc_d;
  logic [31:0] work_d;

`ifdef MDU_DIV_EN
  logic        neg_rem_q;  // remainder takes the dividend's sign
  logic [31:0] src1_q;     // raw dividend, returned in HI on divide by zero
  logic [32:0] div_shift_s;
  logic        div_ge_s;
`endif

  // Iteration results and FIX-stage results
  logic [32:0] mul_sum_s;
  logic [63:0] prod_s;
  logic [63:0] prod_fix_s;
  logic [31:0] hi_fix_d;
  logic [31:0] lo_fix_d;
  logic        dz_fix_d;

  // Decode of the requested operation at the sampling edge
  logic        start_signed_s;
  logic        start_div_s;

  assign start_signed_s = ~op_i[0];
  assign start_div_s    = op_i[1];

  // One multiply or divide iteration on the {acc, work} register.
  always_comb begin
    acc_d     = acc_q;
    work_d    = work_q;
    mul_sum_s = {1'b0, acc_q} + (work_q[0] ? {1'b0, opnd_q} : 33'd0);
`ifdef MDU_DIV_EN
    div_shift_s = {acc_q, work_q[31]};
    div_ge_s    = (div_shift_s >= {1'b0, opnd_q});
`endif
    if (!is_div_q) begin
      // Shift-add: add multiplicand when the multiplier LSB is set, then
      // shift the 65-bit {carry, acc, work} right by one.
      acc_d  = mul_sum_s[32:1];
      work_d = {mul_sum_s[0], work_q[31:1]};
    end else begin
`ifdef MDU_DIV_EN
      // Restoring step: shift in the next dividend bit; subtract the
      // divisor if it fits. When it fits the difference is below the
      // divisor, so its low 32 bits are exact.
      if (div_ge_s) begin
        acc_d  = div_shift_s[31:0] - opnd_q;
        work_d = {work_q[30:0], 1'b1};
      end else begin
        acc_d  = div_shift_s[31:0];
        work_d = {work_q[30:0], 1'b0};
      end
`else
      acc_d  = acc_q;
      work_d = work_q;
`endif
    end
  end

  // Sign correction and special cases applied when leaving CALC.
  always_comb begin
    prod_s     = {acc_q, work_q};
    prod_fix_s = prod_s;
    hi_fix_d   = 32'd0;
    lo_fix_d   = 32'd0;
    dz_fix_d   = 1'b0;
    if (!is_div_q) begin
      if (neg_res_q) begin
        prod_fix_s = neg64(prod_s);
      end else begin
        prod_fix_s = prod_s;
      end
      hi_fix_d = prod_fix_s[63:32];
      lo_fix_d = prod_fix_s[31:0];
      dz_fix_d = 1'b0;
    end else begin
`ifdef MDU_DIV_EN
      if (opnd_q == 32'd0) begin
        hi_fix_d = src1_q;
        lo_fix_d = 32'hFFFF_FFFF;
        dz_fix_d = 1'b1;
      end else begin
        // -2^31 / -1 falls out here as quotient 32'h80000000, remainder 0.
        lo_fix_d = neg_res_q ? neg32(work_q) : work_q;
        hi_fix_d = neg_rem_q ? neg32(acc_q) : acc_q;
        dz_fix_d = 1'b0;
      end
`else
      hi_fix_d = 32'd0;
      lo_fix_d = 32'd0;
      dz_fix_d = 1'b0;
`endif
    end
  end

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 6'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      opnd_q    <= 32'd0;
      acc_q     <= 32'd0;
      work_q    <= 32'd0;
`ifdef MDU_DIV_EN
      neg_rem_q <= 1'b0;
      src1_q    <= 32'd0;
`endif
    end else begin
      done_q <= 1'b0;
      dz_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // MTHI/MTLO land even when start_i is sampled on the same edge;
          // the FIX write of that operation overwrites them later.
          if (hi_we_i) begin
            hi_q <= src1_i;
          end
          if (lo_we_i) begin
            lo_q <= src1_i;
          end
          if (start_i) begin
            state_q   <= ST_CALC;
            busy_q    <= 1'b1;
            cnt_q     <= 6'd0;
            acc_q     <= 32'd0;
            is_div_q  <= start_div_s;
            neg_res_q <= start_signed_s & (src1_i[31] ^ src2_i[31]);
            if (start_div_s) begin
              work_q <= mag32(src1_i, start_signed_s);
              opnd_q <= mag32(src2_i, start_signed_s);
            end else begin
              work_q <= mag32(src2_i, start_signed_s);
              opnd_q <= mag32(src1_i, start_signed_s);
            end
`ifdef MDU_DIV_EN
            neg_rem_q <= start_signed_s & src1_i[31];
            src1_q    <= src1_i;
`endif
          end
        end
        ST_CALC: begin
          acc_q  <= acc_d;
          work_q <= work_d;
          cnt_q  <= cnt_q + 6'd1;
          if (cnt_q == 6'd31) begin
            state_q <= ST_FIX;
          end
        end
        ST_FIX: begin
          hi_q    <= hi_fix_d;
          lo_q    <= lo_fix_d;
          dz_q    <= dz_fix_d;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          cnt_q   <= 6'd0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          cnt_q   <= 6'd0;
        end
      endcase
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign div_zero_o = dz_q;
  assign hi_o       = hi_q;
  assign lo_o       = lo_q;

endmodule
